// File: rtl/mdu_iter_if.sv
// mdu_iter_if: request/cancel handshake and HI/LO result bus between the
// EX stage (master) and the iterative multiply/divide unit (slave).
interface mdu_iter_if #(
  parameter int WIDTH = 32
);
  logic             start;
  logic [3:0]       op;
  logic [WIDTH-1:0] src_a;
  logic [WIDTH-1:0] src_b;
  logic             cancel;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;
  logic             busy;
  logic             done;

  modport master (output start, op, src_a, src_b, cancel,
                  input  hi, lo, busy, done);
  modport slave  (input  start, op, src_a, src_b, cancel,
                  output hi, lo, busy, done);
endinterface

// File: rtl/mdu_iter.sv
// mdu_iter: iterative multiply/divide unit with HI/LO registers.
// Shift-add multiply and restoring divide on operand magnitudes, STEPS bits
// per cycle, followed by one FIX cycle for sign correction and commit.
// Optional feature macro: MDU_MACC_EN enables madd/maddu/msub/msubu (ops 4-7);
// without it those ops are ignored and the accumulator adder is not built.
module mdu_iter #(
  parameter int WIDTH = 32,
  parameter int STEPS = 1
) (
  input  logic      clk,
  input  logic      reset,
  mdu_iter_if.slave bus
);
  localparam int ITER  = WIDTH / STEPS;
  localparam int CNT_W = $clog2(ITER + 1);
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(ITER);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  typedef enum logic [1:0] {S_IDLE, S_CALC, S_FIX} state_t;
  state_t state_reg, state_next;

  logic [CNT_W-1:0] cnt_reg;
  logic [WIDTH-1:0] hi_reg, lo_reg;
  // mult: work_hi = partial product high half, work_lo = multiplier (shifts out)
  // div:  work_hi = partial remainder,         work_lo = dividend / quotient
  logic [WIDTH-1:0] work_hi_reg, work_lo_reg;
  logic [WIDTH-1:0] opnd_reg;   // multiplicand or divisor magnitude
  logic [WIDTH-1:0] raw_a_reg;  // unmodified dividend for the divide-by-zero result
  logic             is_div_reg, neg_q_reg, neg_r_reg, div0_reg, done_reg;
`ifdef MDU_MACC_EN
  logic             acc_en_reg, acc_sub_reg;
`endif

  logic             accept, op_arith, op_signed, op_div;
  logic             a_neg, b_neg;
  logic [WIDTH-1:0] a_mag, b_mag;
  logic [WIDTH-1:0] it_hi, it_lo;
  logic [WIDTH:0]   rem_w, sum_w;
  logic             ge;
  logic [2*WIDTH-1:0] prod, fix_val;
  logic [WIDTH-1:0] quo_s, rem_s;

`ifdef MDU_MACC_EN
  assign op_arith = (bus.op <= 4'd7);
`else
  assign op_arith = (bus.op <= 4'd3);
`endif
  assign op_signed = bus.op[0];
  assign op_div    = (bus.op[3:1] == 3'b001);
  assign accept    = (state_reg == S_IDLE) && bus.start && !bus.cancel;
  assign a_neg     = op_signed && bus.src_a[WIDTH-1];
  assign b_neg     = op_signed && bus.src_b[WIDTH-1];
  assign a_mag     = a_neg ? -bus.src_a : bus.src_a;
  assign b_mag     = b_neg ? -bus.src_b : bus.src_b;

  // State register; async reset returns to IDLE mid-operation.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_reg <= S_IDLE;
    else        state_reg <= state_next;
  end

  // Next-state logic; cancel always wins over progress or commit.
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      S_IDLE:  if (accept && op_arith) state_next = S_CALC;
      S_CALC:  if (bus.cancel) state_next = S_IDLE;
               else if (cnt_reg == CNT_ONE) state_next = S_FIX;
      S_FIX:   state_next = S_IDLE;
      default: state_next = S_IDLE;
    endcase
  end

  // STEPS unsigned shift-add or restoring-divide iterations per cycle.
  always_comb begin
    it_hi = work_hi_reg;
    it_lo = work_lo_reg;
    rem_w = '0;
    sum_w = '0;
    ge    = 1'b0;
    for (int s = 0; s < STEPS; s++) begin
      if (is_div_reg) begin
        rem_w = {it_hi, it_lo[WIDTH-1]};
        ge    = (rem_w >= {1'b0, opnd_reg});
        if (ge) rem_w = rem_w - {1'b0, opnd_reg};
        it_hi = rem_w[WIDTH-1:0];
        it_lo = {it_lo[WIDTH-2:0], ge};
      end else begin
        sum_w = {1'b0, it_hi} + (it_lo[0] ? {1'b0, opnd_reg} : '0);
        it_lo = {sum_w[0], it_lo[WIDTH-1:1]};
        it_hi = sum_w[WIDTH:1];
      end
    end
  end

  // Final HI:LO value: sign fix-up, divide-by-zero result and accumulation.
  always_comb begin
    prod = {work_hi_reg, work_lo_reg};
    if (neg_q_reg) prod = -prod;
    quo_s   = neg_q_reg ? -work_lo_reg : work_lo_reg;
    rem_s   = neg_r_reg ? -work_hi_reg : work_hi_reg;
    fix_val = prod;
    if (is_div_reg)
      fix_val = div0_reg ? {raw_a_reg, {WIDTH{1'b1}}} : {rem_s, quo_s};
`ifdef MDU_MACC_EN
    if (!is_div_reg && acc_en_reg)
      fix_val = acc_sub_reg ? ({hi_reg, lo_reg} - prod) : ({hi_reg, lo_reg} + prod);
`endif
  end

  // Operand capture, iteration registers, HI/LO writes and done pulse.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt_reg     <= '0;
      hi_reg      <= '0;
      lo_reg      <= '0;
      work_hi_reg <= '0;
      work_lo_reg <= '0;
      opnd_reg    <= '0;
      raw_a_reg   <= '0;
      is_div_reg  <= 1'b0;
      neg_q_reg   <= 1'b0;
      neg_r_reg   <= 1'b0;
      div0_reg    <= 1'b0;
      done_reg    <= 1'b0;
`ifdef MDU_MACC_EN
      acc_en_reg  <= 1'b0;
      acc_sub_reg <= 1'b0;
`endif
    end else begin
      done_reg <= 1'b0;
      case (state_reg)
        S_IDLE: if (accept) begin
          if (op_arith) begin
            cnt_reg     <= CNT_LOAD;
            work_hi_reg <= '0;
            work_lo_reg <= op_div ? a_mag : b_mag;
            opnd_reg    <= op_div ? b_mag : a_mag;
            raw_a_reg   <= bus.src_a;
            is_div_reg  <= op_div;
            neg_q_reg   <= a_neg ^ b_neg;
            neg_r_reg   <= a_neg;
            div0_reg    <= (bus.src_b == '0);
`ifdef MDU_MACC_EN
            acc_en_reg  <= bus.op[2];
            acc_sub_reg <= bus.op[1];
`endif
          end else if (bus.op == 4'd8) begin
            hi_reg <= bus.src_a;
          end else if (bus.op == 4'd9) begin
            lo_reg <= bus.src_a;
          end
        end
        S_CALC: if (!bus.cancel) begin
          work_hi_reg <= it_hi;
          work_lo_reg <= it_lo;
          cnt_reg     <= cnt_reg - CNT_ONE;
        end
        S_FIX: if (!bus.cancel) begin
          {hi_reg, lo_reg} <= fix_val;
          done_reg         <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign bus.hi   = hi_reg;
  assign bus.lo   = lo_reg;
  assign bus.busy = (state_reg != S_IDLE);
  assign bus.done = done_reg;
endmodule

// File: tb/tb_mdu_iter.sv
// tb_mdu_iter: directed and randomized checks of mdu_iter against an
// arithmetic reference model of HI/LO. Builds with or without MDU_MACC_EN.
module tb_mdu_iter;
  localparam int WIDTH = 32;
  localparam int STEPS = 1;
  localparam int LAT   = WIDTH / STEPS + 1;
`ifdef MDU_MACC_EN
  localparam bit MACC = 1'b1;
`else
  localparam bit MACC = 1'b0;
`endif

  logic clk = 1'b0;
  logic reset;
  mdu_iter_if #(.WIDTH(WIDTH)) bus ();

  mdu_iter #(.WIDTH(WIDTH), .STEPS(STEPS)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int          n_total = 0;
  int          n_bad   = 0;
  logic [63:0] hilo_m;   // model HI:LO

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Reference: next HI:LO from the op definitions using plain arithmetic.
  function automatic logic [63:0] ref_next(input logic [3:0] o, input logic [31:0] a,
                                           input logic [31:0] b, input logic [63:0] acc);
    logic [63:0] p;
    logic [31:0] q, r;
    longint      la, lb;
    int          sa, sb, sq, sr;
    la = longint'($signed(a));
    lb = longint'($signed(b));
    p  = o[0] ? 64'(la * lb) : ({32'd0, a} * {32'd0, b});
    case (o)
      4'd0, 4'd1: return p;
      4'd2: begin
        if (b == 0) return {a, 32'hFFFFFFFF};
        q = a / b; r = a % b;
        return {r, q};
      end
      4'd3: begin
        if (b == 0) return {a, 32'hFFFFFFFF};
        if (a == 32'h80000000 && b == 32'hFFFFFFFF) return {32'd0, 32'h80000000};
        sa = a; sb = b;
        sq = sa / sb; sr = sa % sb;
        q = sq; r = sr;
        return {r, q};
      end
      4'd4, 4'd5: return MACC ? acc + p : acc;
      4'd6, 4'd7: return MACC ? acc - p : acc;
      4'd8: return {a, acc[31:0]};
      4'd9: return {acc[63:32], a};
      default: return acc;
    endcase
  endfunction

  function automatic logic [31:0] pick_val();
    case ($urandom_range(0, 6))
      0: return 32'd0;
      1: return 32'd1;
      2: return 32'hFFFFFFFF;
      3: return 32'h80000000;
      4: return 32'($urandom_range(0, 20));
      default: return $urandom;
    endcase
  endfunction

  // One complete transaction: issue, wait for completion, compare with model.
  task automatic run_op(input logic [3:0] o, input logic [31:0] a, input logic [31:0] b);
    logic [63:0] exp;
    bit          arith;
    int          cyc, busy_cnt;
    arith = (o <= 4'd3) || (MACC && o <= 4'd7);
    exp   = ref_next(o, a, b, hilo_m);
    @(negedge clk);
    bus.start = 1'b1; bus.op = o; bus.src_a = a; bus.src_b = b;
    @(posedge clk); #1;
    bus.start = 1'b0;
    if (arith) begin
      cyc = 0; busy_cnt = 0;
      if (bus.busy) busy_cnt++;
      while (!bus.done && cyc < LAT + 4) begin
        @(posedge clk); #1;
        cyc++;
        if (bus.busy) busy_cnt++;
      end
      chk("latency", 64'(cyc), 64'(LAT));
      chk("busy_cycles", 64'(busy_cnt), 64'(LAT));
      chk("hilo", {bus.hi, bus.lo}, exp);
      @(posedge clk); #1;
      chk("done_pulse", 64'(bus.done), 64'd0);
    end else begin
      chk("busy_nonarith", 64'(bus.busy), 64'd0);
      chk("done_nonarith", 64'(bus.done), 64'd0);
      chk("hilo_nonarith", {bus.hi, bus.lo}, exp);
    end
    hilo_m = exp;
    $display("op=%0d a=%h b=%h -> hi=%h lo=%h", o, a, b, bus.hi, bus.lo);
  endtask

  // mult 3*5 cancelled at edge at_cyc after accept; a start pulse during busy is ignored.
  task automatic cancel_op(input int at_cyc, input string tag);
    bit done_seen;
    @(negedge clk);
    bus.start = 1'b1; bus.op = 4'd1; bus.src_a = 32'd3; bus.src_b = 32'd5;
    @(posedge clk); #1;
    bus.start = 1'b0;
    @(negedge clk);
    bus.start = 1'b1; bus.op = 4'd8; bus.src_a = 32'hDEADBEEF;
    @(posedge clk); #1;
    bus.start = 1'b0;
    repeat (at_cyc - 2) begin @(posedge clk); #1; end
    @(negedge clk);
    bus.cancel = 1'b1;
    @(posedge clk); #1;
    bus.cancel = 1'b0;
    chk({tag, "_busy"}, 64'(bus.busy), 64'd0);
    done_seen = 1'b0;
    repeat (LAT + 2) begin
      if (bus.done) done_seen = 1'b1;
      @(posedge clk); #1;
    end
    chk({tag, "_nodone"}, 64'(done_seen), 64'd0);
    chk({tag, "_hilo"}, {bus.hi, bus.lo}, hilo_m);
    $display("cancel %s at edge %0d -> hi=%h lo=%h", tag, at_cyc, bus.hi, bus.lo);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [3:0]  o;
    logic [31:0] a, b;

    reset = 1'b0;
    bus.start = 1'b0; bus.op = '0; bus.src_a = '0; bus.src_b = '0; bus.cancel = 1'b0;
    hilo_m = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_hi", 64'(bus.hi), 64'd0);
    chk("rst_lo", 64'(bus.lo), 64'd0);
    chk("rst_busy", 64'(bus.busy), 64'd0);
    chk("rst_done", 64'(bus.done), 64'd0);
    @(negedge clk);
    reset = 1'b1;

    run_op(4'd1, 32'hFFFFFFFF, 32'h2);
    chk("mult_neg", {bus.hi, bus.lo}, 64'hFFFFFFFF_FFFFFFFE);
    run_op(4'd0, 32'hFFFFFFFF, 32'h2);
    chk("multu", {bus.hi, bus.lo}, 64'h00000001_FFFFFFFE);
    run_op(4'd3, 32'hFFFFFFF9, 32'h2);
    chk("div_neg", {bus.hi, bus.lo}, 64'hFFFFFFFF_FFFFFFFD);
    run_op(4'd2, 32'h7, 32'h0);
    chk("divu_zero", {bus.hi, bus.lo}, 64'h00000007_FFFFFFFF);
    run_op(4'd3, 32'h80000000, 32'hFFFFFFFF);
    chk("div_ovf", {bus.hi, bus.lo}, 64'h00000000_80000000);
    run_op(4'd8, 32'h1234, 32'h0);
    chk("mthi", 64'(bus.hi), 64'h1234);
    run_op(4'd9, 32'h5678, 32'h0);
    run_op(4'd12, 32'hAAAA, 32'h5555);
    run_op(4'd15, 32'h1, 32'h1);

    cancel_op(10, "cancel10");
    cancel_op(LAT, "cancel_fix");

    // start together with cancel in IDLE is dropped
    @(negedge clk);
    bus.start = 1'b1; bus.cancel = 1'b1; bus.op = 4'd8; bus.src_a = 32'h55;
    @(posedge clk); #1;
    bus.start = 1'b0; bus.cancel = 1'b0;
    chk("idle_cancel_hilo", {bus.hi, bus.lo}, hilo_m);
    chk("idle_cancel_busy", 64'(bus.busy), 64'd0);
    $display("start+cancel in idle -> hi=%h lo=%h", bus.hi, bus.lo);

    // multiply-accumulate sequence (ignored ops when the feature is absent)
    run_op(4'd8, 32'h0, 32'h0);
    run_op(4'd9, 32'hFFFFFFFF, 32'h0);
    run_op(4'd4, 32'h1, 32'h1);
    run_op(4'd7, 32'h1, 32'h2);
`ifdef MDU_MACC_EN
    chk("macc_seq", {bus.hi, bus.lo}, 64'h00000000_FFFFFFFE);
`else
    chk("macc_ignored", {bus.hi, bus.lo}, 64'h00000000_FFFFFFFF);
`endif

    for (int i = 0; i < 60; i++) begin
      o = 4'($urandom_range(0, 15));
      if (o > 4'd9 && $urandom_range(0, 2) != 0) o = 4'($urandom_range(0, 9));
      a = pick_val();
      b = pick_val();
      run_op(o, a, b);
    end

    // asynchronous reset in the middle of CALC
    run_op(4'd8, 32'hABCD, 32'h0);
    @(negedge clk);
    bus.start = 1'b1; bus.op = 4'd0; bus.src_a = 32'h77; bus.src_b = 32'h99;
    @(posedge clk); #1;
    bus.start = 1'b0;
    repeat (5) @(posedge clk);
    #2;
    reset = 1'b0;
    #1;
    chk("midrst_hi", 64'(bus.hi), 64'd0);
    chk("midrst_lo", 64'(bus.lo), 64'd0);
    chk("midrst_busy", 64'(bus.busy), 64'd0);
    chk("midrst_done", 64'(bus.done), 64'd0);
    $display("reset mid-calc -> hi=%h lo=%h busy=%0d", bus.hi, bus.lo, bus.busy);
    hilo_m = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    run_op(4'd1, 32'hFFFFFFFD, 32'h7);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end
endmodule
